multi_channel_overcurrent_relay: RTL
====================================

# multi_channel_overcurrent_relay

Parametrised successor to the single-channel latching instantaneous relay. It evaluates N_CH RMS current channels (default: three phases) against a common pick-up setting. Each channel has a definite-time element with dropout hysteresis and an optional instantaneous element. Trips are either latching, cleared only by an explicit acknowledge, or self-resetting. The block sits after the per-channel RMS calculators and drives the breaker trip output and the protection status flags.

## Interface
- N_CH, 3: number of current channels.
- WIDTH, 16: unsigned fixed-point current width.
- CNT_W, 16: definite-time sample counter width.

- clk_800hz  in  1  800 Hz system clock.
- reset  in  1  asynchronous, active-high.
- sample_valid  in  1  new I_rms set is valid this cycle.
- I_rms  in  N_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- I_p  in  WIDTH  pick-up threshold.
- I_hyst  in  WIDTH  dropout hysteresis.
- I_inst  in  WIDTH  instantaneous threshold; 0 disables the instantaneous element.
- trip_delay  in  CNT_W  definite-time delay in valid samples.
- latch_en  in  1  1 = latching trip, 0 = self-resetting trip.
- trip_ack  in  1  operator acknowledge; clears latched trips.
- trip_signal  out  1  breaker trip, OR of trip_channels.
- trip_channels  out  N_CH  per-channel tripped flag.
- pickup_flags  out  N_CH  per-channel definite-time timing in progress.
- inst_trip  out  1  current trip was initiated by the instantaneous element.

## Operation
- All comparisons are unsigned and strict (>).
- Dropout level D = (I_hyst >= I_p) ? 0 : I_p − I_hyst. "Above pickup" means I > I_p. "Dropped" means I <= D.
- Settings are sampled live on every valid sample. No shadowing.
- Effective delay: T = max(trip_delay, 1).
- Each channel has an independent FSM (IDLE, TIMING, OPERATED, LATCHED) and a CNT_W counter that saturates at T.
- IDLE, valid sample:
  - instantaneous hit (I_inst ≠ 0 and I > I_inst) → OPERATED;
  - else above pickup and T = 1 → OPERATED;
  - else above pickup → TIMING with cnt = 1;
  - else stay in IDLE.
- TIMING, valid sample:
  - instantaneous hit → OPERATED;
  - dropped → IDLE, cnt = 0;
  - otherwise (including D < I <= I_p) cnt + 1; when cnt + 1 >= T → OPERATED, else stay in TIMING.
- OPERATED, valid sample:
  - dropped and latch_en = 0 → IDLE;
  - dropped and latch_en = 1 → LATCHED;
  - otherwise stay. trip_ack is ignored in OPERATED.
- LATCHED:
  - valid sample above pickup → OPERATED (no re-timing). This takes priority over trip_ack in the same cycle.
  - else trip_ack = 1 → IDLE;
  - else latch_en = 0 → IDLE.
- sample_valid = 0: only the LATCHED exits (trip_ack, latch_en) may fire. Counters hold.
- Per-channel outputs:
  - trip_channels[k] = state in {OPERATED, LATCHED};
  - pickup_flags[k] = state is TIMING.
- inst_trip is set when any channel enters OPERATED through an instantaneous hit. It is cleared on the edge where trip_signal falls to 0.

## Timing
- Reset is asynchronous: all FSMs go to IDLE, counters to 0, and every output to 0 immediately. Behaviour is the same when reset lands mid-timing or while tripped. Release is synchronous to clk_800hz.
- All outputs are registered and update on the same edge as the FSM transition. Latency is one clock from the sample_valid cycle to the output change.
- Definite-time trip asserts on the edge that samples the T-th consecutive non-dropped valid sample, counting the first above-pickup sample as 1.
- Instantaneous trip asserts on the edge of the first offending sample, regardless of state or trip_delay.
- Latched clear: trip_channels and trip_signal fall on the edge after trip_ack is sampled high.
- Channels are fully independent. Simultaneous events on different channels resolve per-channel in the same cycle.

## Test plan
- Reset: with trip_signal = 1, assert reset between clock edges → all outputs 0 before the next edge, and they stay 0 until reset is released.
- Definite time: I_p = 1000, I_hyst = 100, trip_delay = 4, ch1 = 1200 on four valid samples:
  - pickup_flags = 3'b010 after sample 1;
  - trip_signal = 1 and trip_channels = 3'b010 on the edge of sample 4.
- Hysteresis: same settings.
  - ch0 = 1200, 1200, 950, 1200 → trip on sample 4.
  - ch0 = 1200, 1200, 850, 1200 → no trip; TIMING restarts with cnt = 1.
- Instantaneous: I_inst = 5000, trip_delay = 100, ch2 = 6000 for one valid sample → trip_signal = 1, trip_channels = 3'b100, inst_trip = 1 on that edge.
- Latching: latch_en = 1, trip ch0, then ch0 = 500:
  - trip is held;
  - trip_ack while ch0 = 1200 has no effect;
  - trip_ack after ch0 = 500 clears on the next edge.
  - Repeat with latch_en = 0 → trip falls on the first 500 sample.
- Simultaneous: ch0 LATCHED, trip_ack = 1 in the same cycle as a valid ch0 = 1200 sample → state goes to OPERATED and trip_signal stays 1.

Source files
------------

// File: rtl/multi_channel_overcurrent_relay_if.sv
// Purpose : bundle of settings, sample strobe and trip status for the overcurrent relay.
// Latency : n/a (wires only).
// Backpressure: none; sample_valid is a one-cycle qualifier with no ready return.
// Ports   : master drives the samples and settings and reads the status; slave is the relay.
//           The parameters must match the relay instance that uses this bundle.
interface multi_channel_overcurrent_relay_if #(
   parameter int N_CH  = 3,
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
);
   logic                    sample_valid;
   logic [N_CH*WIDTH-1:0]   I_rms;
   logic [WIDTH-1:0]        I_p;
   logic [WIDTH-1:0]        I_hyst;
   logic [WIDTH-1:0]        I_inst;
   logic [CNT_W-1:0]        trip_delay;
   logic                    latch_en;
   logic                    trip_ack;
   logic                    trip_signal;
   logic [N_CH-1:0]         trip_channels;
   logic [N_CH-1:0]         pickup_flags;
   logic                    inst_trip;

   modport master (
      output sample_valid, I_rms, I_p, I_hyst, I_inst, trip_delay, latch_en, trip_ack,
      input  trip_signal, trip_channels, pickup_flags, inst_trip
   );

   modport slave (
      input  sample_valid, I_rms, I_p, I_hyst, I_inst, trip_delay, latch_en, trip_ack,
      output trip_signal, trip_channels, pickup_flags, inst_trip
   );
endinterface

// File: rtl/multi_channel_overcurrent_relay.sv
// Purpose : per-channel definite-time / instantaneous overcurrent relay with latching or self-reset trips.
// Latency : one clk_800hz edge from the sampled inputs to every registered output.
// Backpressure: none; a sample is consumed whenever sample_valid is high.
// Ports   : clk_800hz, reset (async, active-high); bus (slave modport) carries I_rms, the settings,
//           trip_ack and the trip_signal / trip_channels / pickup_flags / inst_trip status.
module multi_channel_overcurrent_relay #(
   parameter int N_CH  = 3,
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                          clk_800hz,
   input  logic                          reset,
   multi_channel_overcurrent_relay_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TIMING   = 2'd1,
      OPERATED = 2'd2,
      LATCHED  = 2'd3
   } ch_state_t;

   ch_state_t        state     [N_CH];
   ch_state_t        nxt_state [N_CH];
   logic [CNT_W-1:0] cnt       [N_CH];
   logic [CNT_W-1:0] nxt_cnt   [N_CH];
   logic [CNT_W:0]   cnt_inc   [N_CH];

   logic [N_CH-1:0]  above;
   logic [N_CH-1:0]  dropped;
   logic [N_CH-1:0]  inst_hit;
   logic [N_CH-1:0]  inst_entry;
   logic [N_CH-1:0]  nxt_trip;
   logic [N_CH-1:0]  nxt_pick;

   logic [WIDTH-1:0] drop_lvl;
   logic [CNT_W-1:0] t_eff;

   // Dropout level clamps at zero when the hysteresis band exceeds the pick-up.
   assign drop_lvl = (bus.I_hyst >= bus.I_p) ? '0 : (bus.I_p - bus.I_hyst);
   // A zero delay behaves like a one-sample delay.
   assign t_eff    = (bus.trip_delay == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : bus.trip_delay;

   for (genvar k = 0; k < N_CH; k++) begin : g_cmp
      logic [WIDTH-1:0] cur;
      assign cur         = bus.I_rms[k*WIDTH +: WIDTH];
      assign above[k]    = cur > bus.I_p;
      assign dropped[k]  = cur <= drop_lvl;
      assign inst_hit[k] = (bus.I_inst != '0) && (cur > bus.I_inst);
      // One extra bit so the increment can never wrap before the >= T test.
      assign cnt_inc[k]  = {1'b0, cnt[k]} + {{CNT_W{1'b0}}, 1'b1};
   end

   always_comb begin
      for (int k = 0; k < N_CH; k++) begin
         nxt_state[k]  = state[k];
         nxt_cnt[k]    = cnt[k];
         inst_entry[k] = 1'b0;
         case (state[k])
            IDLE: begin
               if (bus.sample_valid) begin
                  if (inst_hit[k]) begin
                     nxt_state[k]  = OPERATED;
                     inst_entry[k] = 1'b1;
                  end else if (above[k] && (t_eff == {{(CNT_W-1){1'b0}}, 1'b1})) begin
                     nxt_state[k] = OPERATED;
                  end else if (above[k]) begin
                     nxt_state[k] = TIMING;
                     nxt_cnt[k]   = {{(CNT_W-1){1'b0}}, 1'b1};
                  end
               end
            end
            TIMING: begin
               if (bus.sample_valid) begin
                  if (inst_hit[k]) begin
                     nxt_state[k]  = OPERATED;
                     inst_entry[k] = 1'b1;
                  end else if (dropped[k]) begin
                     nxt_state[k] = IDLE;
                     nxt_cnt[k]   = '0;
                  end else if (cnt_inc[k] >= {1'b0, t_eff}) begin
                     // Counter saturates at T once the element operates.
                     nxt_state[k] = OPERATED;
                     nxt_cnt[k]   = t_eff;
                  end else begin
                     nxt_cnt[k] = cnt_inc[k][CNT_W-1:0];
                  end
               end
            end
            OPERATED: begin
               // Acknowledge is deliberately ignored while current is still present.
               if (bus.sample_valid && dropped[k]) begin
                  nxt_state[k] = bus.latch_en ? LATCHED : IDLE;
                  nxt_cnt[k]   = bus.latch_en ? cnt[k] : '0;
               end
            end
            LATCHED: begin
               // A fresh overcurrent re-operates at once and wins over a coincident acknowledge.
               if (bus.sample_valid && above[k]) begin
                  nxt_state[k] = OPERATED;
               end else if (bus.trip_ack || !bus.latch_en) begin
                  nxt_state[k] = IDLE;
                  nxt_cnt[k]   = '0;
               end
            end
            default: begin
               nxt_state[k] = IDLE;
               nxt_cnt[k]   = '0;
            end
         endcase
         nxt_trip[k] = (nxt_state[k] == OPERATED) || (nxt_state[k] == LATCHED);
         nxt_pick[k] = (nxt_state[k] == TIMING);
      end
   end

   always_ff @(posedge clk_800hz or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_CH; k++) begin
            state[k] <= IDLE;
            cnt[k]   <= '0;
         end
         bus.trip_signal   <= 1'b0;
         bus.trip_channels <= '0;
         bus.pickup_flags  <= '0;
         bus.inst_trip     <= 1'b0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            state[k] <= nxt_state[k];
            cnt[k]   <= nxt_cnt[k];
         end
         bus.trip_signal   <= |nxt_trip;
         bus.trip_channels <= nxt_trip;
         bus.pickup_flags  <= nxt_pick;
         // inst_trip tracks the trip episode: it survives until the breaker output falls.
         if (!(|nxt_trip)) begin
            bus.inst_trip <= 1'b0;
         end else if (|inst_entry) begin
            bus.inst_trip <= 1'b1;
         end
      end
   end

endmodule
